// File: rtl/bsg_wormhole_router_adapter_in_serializer.sv
// Wormhole router input adapter: registers one packet and
// streams it out as fixed-width flits, header in flit 0.
module bsg_wormhole_router_adapter_in_serializer #(
  parameter int max_num_flit_p = 4,
  parameter int max_payload_width_p = 537,
  parameter int x_cord_width_p = 1,
  parameter int y_cord_width_p = 1,
  localparam int len_width = $clog2(max_num_flit_p),
  localparam int packet_width = max_payload_width_p + len_width
                              + x_cord_width_p + y_cord_width_p,
  localparam int flit_width = (packet_width + max_num_flit_p - 1)
                            / max_num_flit_p
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [packet_width-1:0] data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [flit_width-1:0]   data_o,
  output logic                    v_o,
  input  logic                    ready_i
);

  localparam int len_lsb = x_cord_width_p + y_cord_width_p;
  localparam int pad_width = flit_width * max_num_flit_p;

  typedef enum logic {IDLE, SEND} state_e;

  state_e state, state_n;

  logic [packet_width-1:0] pkt_r;
  logic [len_width-1:0]    len_r;
  logic [len_width-1:0]    count_r;
  logic [pad_width-1:0]    pkt_pad;
  logic                    accept;
  logic                    xfer;
  logic                    last;

  assign last = (count_r == len_r);

  // zero-extend the packet so the top flit carries zero padding
  always_comb begin
    pkt_pad = '0;
    pkt_pad[packet_width-1:0] = pkt_r;
  end

  assign data_o = pkt_pad[count_r*flit_width +: flit_width];

  // state register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_n;
  end

  // next state and handshake outputs
  always_comb begin
    state_n = state;
    ready_o = 1'b0;
    v_o     = 1'b0;
    accept  = 1'b0;
    xfer    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_o = reset_n_i;
        accept  = v_i;
        if (v_i) state_n = SEND;
      end
      SEND: begin
        v_o  = 1'b1;
        xfer = ready_i;
        if (ready_i && last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // packet capture and flit counter
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pkt_r   <= '0;
      len_r   <= '0;
      count_r <= '0;
    end else if (accept) begin
      pkt_r   <= data_i;
      len_r   <= data_i[len_lsb +: len_width];
      count_r <= '0;
    end else if (xfer && !last) begin
      count_r <= count_r + 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_in_serializer.sv
// Bench for the wormhole input serializer: flit-queue model,
// packet reassembly, directed cases and random traffic.
module tb_bsg_wormhole_router_adapter_in_serializer;

  localparam int PW = 541;
  localparam int FW = 136;
  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [PW-1:0] data_i;
  logic          v_i;
  logic          ready_o;
  logic [FW-1:0] data_o;
  logic          v_o;
  logic          ready_i;

  int total = 0;
  int bad = 0;
  bit armed = 0;

  logic [FW-1:0] q[$];
  logic [PW-1:0] sent_q[$];
  int            n_acc = 0;

  logic [NF*FW-1:0] rx_buf = '0;
  int               rx_n = 0;
  logic [1:0]       rx_len = '0;

  bsg_wormhole_router_adapter_in_serializer dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .v_o       (v_o),
    .ready_i   (ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] flit_of(logic [PW-1:0] p, int k);
    logic [NF*FW-1:0] w;
    w = {3'b0, p};
    return w[k*FW +: FW];
  endfunction

  function automatic logic [PW-1:0] mk(logic [536:0] pl, logic [1:0] len,
                                      logic y, logic x);
    return {pl, len, y, x};
  endfunction

  function automatic logic [536:0] rnd();
    logic [543:0] w;
    for (int i = 0; i < 17; i++) w[i*32 +: 32] = $urandom;
    return w[536:0];
  endfunction

  task automatic chk(string nm, logic [FW-1:0] act, logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: queue of flits owed to the router
  always @(posedge clk) begin
    bit e;
    if (!reset_n) begin
      q.delete();
      sent_q.delete();
      rx_n = 0;
      rx_buf = '0;
    end else begin
      e = (q.size() == 0);
      if (!e && ready_i) void'(q.pop_front());
      if (e && v_i) begin
        for (int k = 0; k <= int'(data_i[3:2]); k++)
          q.push_back(flit_of(data_i, k));
        sent_q.push_back(data_i);
        n_acc++;
      end
    end
  end

  // per-cycle compare plus reassembly of transferred flits
  always @(negedge clk) begin
    int nb;
    logic [NF*FW-1:0] m;
    logic [NF*FW-1:0] ew;
    if (armed) begin
      chk1("v_o", v_o, q.size() != 0);
      chk1("ready_o", ready_o, reset_n && q.size() == 0);
      if (q.size() != 0) chk("data_o", data_o, q[0]);
      if (reset_n && v_o && ready_i) begin
        if (rx_n == 0) rx_len = data_o[3:2];
        rx_buf[rx_n*FW +: FW] = data_o;
        rx_n++;
        if (rx_n == int'(rx_len) + 1) begin
          nb = rx_n * FW;
          m = '1;
          if (nb < NF*FW) m = ((NF*FW)'(1) << nb) - 1'b1;
          total++;
          if (sent_q.size() == 0) begin
            bad++;
            $display("FAIL roundtrip: packet with no accept");
          end else begin
            ew = {3'b0, sent_q.pop_front()};
            if ((rx_buf & m) !== (ew & m)) begin
              bad++;
              $display("FAIL roundtrip: got %h want %h",
                       rx_buf & m, ew & m);
            end
          end
          rx_n = 0;
          rx_buf = '0;
        end
      end
    end
  end

  initial begin
    logic [PW-1:0] p, a, b;
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int xfers, ek, cyc, start;

    reset_n = 1'b0;
    v_i = 1'b0;
    ready_i = 1'b0;
    data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    armed = 1;
    chk1("rst_ready", ready_o, 1'b0);
    chk1("rst_v", v_o, 1'b0);
    chk("rst_data", data_o, '0);
    step();
    reset_n = 1'b1;
    step();
    chk1("ready_after_rst", ready_o, 1'b1);

    // single flit
    p = mk(537'h1ABC, 2'd0, 1'b0, 1'b1);
    data_i = p;
    v_i = 1'b1;
    ready_i = 1'b1;
    step();
    v_i = 1'b0;
    chk1("t1_v", v_o, 1'b1);
    chk1("t1_busy", ready_o, 1'b0);
    chk("t1_flit", data_o, 136'h1ABC1);
    step();
    chk1("t1_ready", ready_o, 1'b1);
    chk1("t1_v_low", v_o, 1'b0);

    // four flits, no backpressure
    p = mk(rnd(), 2'd3, 1'($urandom), 1'($urandom));
    data_i = p;
    v_i = 1'b1;
    step();
    v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("t2_v", v_o, 1'b1);
      chk1("t2_busy", ready_o, 1'b0);
      chk("t2_flit", data_o, flit_of(p, i));
      if (i == 3) chk1("t2_pad", data_o[135:133] == 3'b0, 1'b1);
      step();
    end
    chk1("t2_ready", ready_o, 1'b1);

    // backpressure
    p = mk(rnd(), 2'd2, 1'($urandom), 1'($urandom));
    ready_i = 1'b0;
    data_i = p;
    v_i = 1'b1;
    step();
    v_i = 1'b0;
    xfers = 0;
    ek = 0;
    for (int i = 0; i < 6; i++) begin
      ready_i = pat[i][0];
      chk1("t3_v", v_o, 1'b1);
      chk("t3_flit", data_o, flit_of(p, ek));
      if (v_o && ready_i) xfers++;
      step();
      if (pat[i] == 1) ek++;
    end
    chk("t3_xfers", FW'(xfers), FW'(3));
    chk1("t3_v_end", v_o, 1'b0);
    ready_i = 1'b1;

    // back-to-back with v_i held high
    a = mk(rnd(), 2'd1, 1'($urandom), 1'($urandom));
    b = mk(rnd(), 2'd0, 1'($urandom), 1'($urandom));
    data_i = a;
    v_i = 1'b1;
    step();
    data_i = b;
    chk("t4_a0", data_o, flit_of(a, 0));
    chk1("t4_busy", ready_o, 1'b0);
    step();
    chk("t4_a1", data_o, flit_of(a, 1));
    step();
    chk1("t4_gap_ready", ready_o, 1'b1);
    chk1("t4_gap_v", v_o, 1'b0);
    step();
    v_i = 1'b0;
    chk1("t4_b_v", v_o, 1'b1);
    chk("t4_b0", data_o, flit_of(b, 0));
    step();
    chk1("t4_done", v_o, 1'b0);

    // reset mid-packet
    p = mk(rnd(), 2'd3, 1'($urandom), 1'($urandom));
    data_i = p;
    v_i = 1'b1;
    step();
    v_i = 1'b0;
    step();
    step();
    chk("t5_f2", data_o, flit_of(p, 2));
    reset_n = 1'b0;
    step();
    chk1("t5_v", v_o, 1'b0);
    chk("t5_data", data_o, '0);
    chk1("t5_ready_rst", ready_o, 1'b0);
    reset_n = 1'b1;
    step();
    chk1("t5_ready", ready_o, 1'b1);
    p = mk(rnd(), 2'd0, 1'($urandom), 1'($urandom));
    data_i = p;
    v_i = 1'b1;
    step();
    v_i = 1'b0;
    chk("t5_new", data_o, flit_of(p, 0));
    step();
    chk1("t5_new_done", v_o, 1'b0);

    // random traffic with stalls
    start = n_acc;
    cyc = 0;
    while (n_acc - start < 1000 && cyc < 30000) begin
      ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) != 0) begin
        v_i = 1'b1;
        data_i = mk(rnd(), 2'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom));
      end else begin
        v_i = 1'b0;
      end
      step();
      cyc++;
    end
    v_i = 1'b0;
    total++;
    if (n_acc - start < 1000) begin
      bad++;
      $display("FAIL random_budget: got %0d packets want 1000",
               n_acc - start);
    end
    ready_i = 1'b1;
    repeat (8) step();
    chk1("drain_v", v_o, 1'b0);
    chk1("drain_ready", ready_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
